exec_sequencer: RTL

//  Multi-cycle controller that sequences one shared execute datapath (ALU_Control + operand MUX + ALU).

---
 rtl/exec_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle controller for one shared execute datapath
// (ALU_Control + operand MUX + ALU).
// - Non-branch operations take one ALU pass.
// - Conditional branches take two passes through the same ALU: a compare
//   pass, then a PC+imm target pass.
// - All ALU drive signals and result fields come straight from registers.
//   The ALU output is sampled only on the clock edge that ends each pass.
module exec_sequencer #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_rs1,
   input  logic [XLEN-1:0]  in_rs2,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [XLEN-1:0]  in_pc,
   input  logic             in_alusrc,
   input  logic [1:0]       in_aluop,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic             in_is_branch,
   output logic [XLEN-1:0]  alu_a,
   output logic [XLEN-1:0]  alu_b,
   output logic [1:0]       alu_aluop,
   output logic [2:0]       alu_funct3,
   output logic [6:0]       alu_funct7,
   input  logic [XLEN-1:0]  alu_result,
   input  logic             alu_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic             out_taken,
   output logic [XLEN-1:0]  out_target,
   output logic             out_bad_br,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXEC   = 2'd1,
      S_TARGET = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           r_state;

   // Fields captured at accept time that are still needed after the
   // first pass: the target pass uses pc/imm, the branch decision uses funct3.
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_imm;
   logic [2:0]       r_funct3;
   logic             r_is_branch;

   logic [XLEN-1:0]  r_alu_a;
   logic [XLEN-1:0]  r_alu_b;
   logic [1:0]       r_alu_aluop;
   logic [2:0]       r_alu_funct3;
   logic [6:0]       r_alu_funct7;

   logic             r_out_valid;
   logic [XLEN-1:0]  r_out_result;
   logic             r_out_taken;
   logic [XLEN-1:0]  r_out_target;
   logic             r_out_bad_br;
   logic [CNT_W-1:0] r_op_count;

   // Operand B for the first pass (register vs immediate).
   logic [XLEN-1:0]  w_first_b;
   // Branch verdict from the compare pass: BEQ takes on zero, BNE on
   // non-zero; any other funct3 is a malformed branch and is never taken.
   logic             w_br_taken;
   logic             w_br_bad;

   assign w_first_b  = in_alusrc ? in_imm : in_rs2;
   assign w_br_taken = (r_funct3 == 3'b000) ? alu_zero
                     : (r_funct3 == 3'b001) ? ~alu_zero
                     : 1'b0;
   assign w_br_bad   = (r_funct3 != 3'b000) && (r_funct3 != 3'b001);

   // in_ready is a direct decode of the state register, so it is 1 as soon
   // as reset is released. Only one operation is ever in flight: DONE must
   // drain back to IDLE before the next request is accepted.
   assign in_ready   = (r_state == S_IDLE);
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_aluop  = r_alu_aluop;
   assign alu_funct3 = r_alu_funct3;
   assign alu_funct7 = r_alu_funct7;
   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_taken  = r_out_taken;
   assign out_target = r_out_target;
   assign out_bad_br = r_out_bad_br;
   assign op_count   = r_op_count;

   // Sequencer FSM: the next pass's ALU drive is loaded on the same edge
   // that samples the current pass's result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_pc         <= {XLEN{1'b0}};
         r_imm        <= {XLEN{1'b0}};
         r_funct3     <= 3'b000;
         r_is_branch  <= 1'b0;
         r_alu_a      <= {XLEN{1'b0}};
         r_alu_b      <= {XLEN{1'b0}};
         r_alu_aluop  <= 2'b00;
         r_alu_funct3 <= 3'b000;
         r_alu_funct7 <= 7'b0000000;
         r_out_valid  <= 1'b0;
         r_out_result <= {XLEN{1'b0}};
         r_out_taken  <= 1'b0;
         r_out_target <= {XLEN{1'b0}};
         r_out_bad_br <= 1'b0;
         r_op_count   <= {CNT_W{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_pc         <= in_pc;
                  r_imm        <= in_imm;
                  r_funct3     <= in_funct3;
                  r_is_branch  <= in_is_branch;
                  r_alu_a      <= in_rs1;
                  r_alu_b      <= w_first_b;
                  r_alu_aluop  <= in_aluop;
                  r_alu_funct3 <= in_funct3;
                  r_alu_funct7 <= in_funct7;
                  r_state      <= S_EXEC;
               end else begin
                  r_state      <= S_IDLE;
               end
            end
            S_EXEC: begin
               r_out_result <= alu_result;
               r_out_target <= {XLEN{1'b0}};
               if (r_is_branch) begin
                  r_out_taken  <= w_br_taken;
                  r_out_bad_br <= w_br_bad;
                  // Second pass through the same ALU: plain add of PC + imm.
                  r_alu_a      <= r_pc;
                  r_alu_b      <= r_imm;
                  r_alu_aluop  <= 2'b00;
                  r_alu_funct3 <= 3'b000;
                  r_alu_funct7 <= 7'b0000000;
                  r_state      <= S_TARGET;
               end else begin
                  r_out_taken  <= 1'b0;
                  r_out_bad_br <= 1'b0;
                  r_alu_a      <= {XLEN{1'b0}};
                  r_alu_b      <= {XLEN{1'b0}};
                  r_alu_aluop  <= 2'b00;
                  r_alu_funct3 <= 3'b000;
                  r_alu_funct7 <= 7'b0000000;
                  r_out_valid  <= 1'b1;
                  r_state      <= S_DONE;
               end
            end
            S_TARGET: begin
               r_out_target <= alu_result;
               r_alu_a      <= {XLEN{1'b0}};
               r_alu_b      <= {XLEN{1'b0}};
               r_alu_aluop  <= 2'b00;
               r_alu_funct3 <= 3'b000;
               r_alu_funct7 <= 7'b0000000;
               r_out_valid  <= 1'b1;
               r_state      <= S_DONE;
            end
            S_DONE: begin
               // Results stay frozen until the consumer takes them.
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_op_count  <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
                  r_state     <= S_IDLE;
               end else begin
                  r_state     <= S_DONE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
